// File: rtl/ram2_lsu_pkg.sv
// Shared types and lane helpers for the Ram2 load/store unit.
// Size encodings, FSM state enum, and little-endian lane extract/merge functions.
package ram2_lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ST_RD = 3'd2,
      ST_WR = 3'd3,
      RESP  = 3'd4
   } state_e;

   // Pull the addressed byte/half down to bit 0, then sign- or zero-extend.
   function automatic logic [31:0] lane_extract(
      input logic [31:0] word,
      input logic [1:0]  off,
      input logic [1:0]  size,
      input logic        sgn
   );
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (size)
         SZ_BYTE: return {{24{sgn & sh[7]}}, sh[7:0]};
         SZ_HALF: return {{16{sgn & sh[15]}}, sh[15:0]};
         default: return word;
      endcase
   endfunction

   // Replace the addressed lane(s) of word with the low bits of wdata.
   function automatic logic [31:0] lane_merge(
      input logic [31:0] word,
      input logic [31:0] wdata,
      input logic [1:0]  off,
      input logic [1:0]  size
   );
      logic [31:0] mask;
      logic [31:0] data;
      case (size)
         SZ_BYTE: begin
            mask = 32'h0000_00FF << {off, 3'b000};
            data = {4{wdata[7:0]}};
         end
         SZ_HALF: begin
            mask = 32'h0000_FFFF << {off, 3'b000};
            data = {2{wdata[15:0]}};
         end
         default: begin
            mask = 32'hFFFF_FFFF;
            data = wdata;
         end
      endcase
      return (word & ~mask) | (data & mask);
   endfunction

endpackage

// File: rtl/ram2_lsu_lane.sv
// Combinational lane unit: extract/extend for loads, read-modify-write merge for
// sub-word stores. Both paths share the same latched offset and size.
module ram2_lsu_lane
   import ram2_lsu_pkg::*;
(
   input  logic [31:0] rd_word_i,
   input  logic [31:0] wdata_i,
   input  logic [1:0]  off_i,
   input  logic [1:0]  size_i,
   input  logic        sgn_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merge_data_o
);

   assign load_data_o  = lane_extract(rd_word_i, off_i, size_i, sgn_i);
   assign merge_data_o = lane_merge(rd_word_i, wdata_i, off_i, size_i);

endmodule

// File: rtl/ram2_lsu.sv
// Load/store initiator in front of the word-addressed Ram2 data memory.
// Optional RAM2_LSU_PERF_EN adds saturating load/store/error counters.
module ram2_lsu
   import ram2_lsu_pkg::*;
#(
   parameter int  WORD_WIDTH = 32,
   parameter int  ENTRIES    = 100,
   localparam int AW         = $clog2(ENTRIES)
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [31:0]           req_addr,
   input  logic [WORD_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [WORD_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic [AW-1:0]         ram_A,
   output logic [WORD_WIDTH-1:0] ram_WD,
   output logic                  ram_WE,
   input  logic [WORD_WIDTH-1:0] ram_RD
`ifdef RAM2_LSU_PERF_EN
   ,
   output logic [31:0]           load_cnt,
   output logic [31:0]           store_cnt,
   output logic [31:0]           err_cnt
`endif
);

   localparam logic [29:0] ENTRIES_W = 30'(ENTRIES);

   state_e      state_q, state_d;
   logic [AW+1:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] merge_q, merge_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        req_err;
   logic [31:0] lane_load;
   logic [31:0] lane_merged;

   ram2_lsu_lane u_lane (
      .rd_word_i    (ram_RD),
      .wdata_i      (wdata_q),
      .off_i        (addr_q[1:0]),
      .size_i       (size_q),
      .sgn_i        (signed_q),
      .load_data_o  (lane_load),
      .merge_data_o (lane_merged)
   );

   always_comb begin
      req_err = 1'b0;
      if (req_size == SZ_ILL)                          req_err = 1'b1;
      if (req_size == SZ_HALF && req_addr[0])          req_err = 1'b1;
      if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) req_err = 1'b1;
      if (req_addr[31:2] >= ENTRIES_W)                 req_err = 1'b1;
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      size_d   = size_q;
      signed_d = signed_q;
      wdata_d  = wdata_q;
      merge_d  = merge_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d   = req_addr[AW+1:0];
               size_d   = req_size;
               signed_d = req_signed;
               wdata_d  = req_wdata;
               rdata_d  = '0;
               err_d    = req_err;
               if (req_err)               state_d = RESP;
               else if (!req_we)          state_d = LOAD;
               else if (req_size == SZ_WORD) state_d = ST_WR;
               else                       state_d = ST_RD;
            end
         end
         LOAD: begin
            rdata_d = lane_load;
            state_d = RESP;
         end
         ST_RD: begin
            merge_d = lane_merged;
            state_d = ST_WR;
         end
         ST_WR:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         size_q   <= SZ_BYTE;
         signed_q <= 1'b0;
         wdata_q  <= '0;
         merge_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         wdata_q  <= wdata_d;
         merge_q  <= merge_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_err   = (state_q == RESP) & err_q;
   assign resp_rdata = (state_q == RESP) ? rdata_q : '0;

   // Memory port is idle (all zero) outside the three access states.
   assign ram_A  = (state_q == LOAD || state_q == ST_RD || state_q == ST_WR)
                   ? addr_q[AW+1:2] : '0;
   assign ram_WD = (state_q == ST_WR) ? ((size_q == SZ_WORD) ? wdata_q : merge_q) : '0;
   assign ram_WE = (state_q == ST_WR) & ~Rst;

`ifdef RAM2_LSU_PERF_EN
   logic store_cls_q;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         store_cls_q <= 1'b0;
         load_cnt    <= '0;
         store_cnt   <= '0;
         err_cnt     <= '0;
      end else begin
         if (state_q == IDLE && req_valid) store_cls_q <= req_we;
         if (state_q == RESP) begin
            if (err_q) begin
               if (err_cnt != 32'hFFFF_FFFF) err_cnt <= err_cnt + 32'd1;
            end else if (store_cls_q) begin
               if (store_cnt != 32'hFFFF_FFFF) store_cnt <= store_cnt + 32'd1;
            end else begin
               if (load_cnt != 32'hFFFF_FFFF) load_cnt <= load_cnt + 32'd1;
            end
         end
      end
   end
`endif

endmodule

// File: doc/ram2_lsu.md
Name: ram2_lsu

Overview:
- Load/store initiator that sits between the MIPS datapath and the Ram2 data memory.
- Accepts byte-addressed load and store requests of byte, halfword and word size, and drives Ram2's word-addressed A/WD/WE port while consuming RD.
- Implements sub-word stores as read-modify-write, and sign- or zero-extends sub-word loads.
- Reports misaligned or out-of-range accesses as errors.

Parameters:
- WORD_WIDTH, 32, data width. Only 32 is supported: four little-endian byte lanes.
- ENTRIES, 100, Ram2 depth in words.
- AW, $clog2(ENTRIES), Ram2 word-address width (localparam).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  sign-extend sub-word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low bits are used for sub-word stores.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid.
- ram_A  out  AW  word address to Ram2 (addr[AW+1:2]).
- ram_WD  out  32  write data to Ram2.
- ram_WE  out  1  write enable to Ram2.
- ram_RD  in  32  Ram2 combinational read data.

Behaviour:
- Ram2 model: reads are combinational from ram_A; writes occur on the Clk edge when ram_WE=1.
- States: IDLE, LOAD, ST_RD, ST_WR, RESP.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, ram_WE=0, ram_A=0, ram_WD=0.
- Acceptance: a request is accepted at the edge where req_valid & req_ready. addr, size, signed, we and wdata are latched at that edge.
- Error check at acceptance; any one of these makes the request an error:
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:2] >= ENTRIES.
- Error path: next state is RESP with resp_err=1. Ram2 is never accessed and ram_WE is never asserted.
- Transitions from IDLE on a legal request:
  - load → LOAD;
  - word store → ST_WR;
  - byte or half store → ST_RD.
- LOAD: drive ram_A. Select the lane by addr[1:0] (byte) or addr[1] (half), little-endian, then extend:
  - req_signed=1: sign-extend;
  - req_signed=0: zero-extend.
  Register the result into resp_rdata. Next state RESP.
- ST_RD: drive ram_A. Register merge = ram_RD with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0]. Next state ST_WR.
- ST_WR: drive ram_A, ram_WD = merge (or wdata for a word store), ram_WE=1 for exactly one cycle. Next state RESP.
- RESP: resp_valid=1 for one cycle, then IDLE.
- ram_A, ram_WD and ram_WE are decoded from state and latched registers. They are 0 in IDLE and RESP.
- Latency, acceptance edge to resp_valid high:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- Back-to-back: the earliest next acceptance is the edge that ends RESP. No pipelining and no backpressure on the response.
- Reset mid-operation: ram_WE is gated with ~Rst, so no Ram2 write occurs on an edge where Rst=1. The FSM returns to IDLE and any pending response is dropped. Ram2 contents are untouched by this block.
- req_* inputs are ignored outside IDLE.

Optional Feature:
- Macro: RAM2_LSU_PERF_EN.
- When defined, adds output ports load_cnt[31:0], store_cnt[31:0] and err_cnt[31:0]:
  - each counter is incremented on the RESP cycle of its access class;
  - each counter saturates at 32'hFFFF_FFFF;
  - all three are cleared by Rst.
- When undefined, these ports and their registers do not exist and the rest of the behaviour is identical.

Decomposition:
- Package ram2_lsu_pkg holds:
  - the size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state enum;
  - the lane_extract and lane_merge functions.
- One natural sub-module: ram2_lsu_lane, a combinational lane extract/extend and merge unit shared by the LOAD and ST_RD paths.
- The FSM stays in ram2_lsu.

Test Plan:
- Word store 0xFABC to addr 0x0, then word load from 0x0 → ram_WE pulses once with ram_A=0 and ram_WD=0x0000FABC. The load returns 0x0000FABC two cycles after acceptance.
- Word 0x11223344 at addr 0x10, then store byte 0xAA to 0x12 → ST_RD then ST_WR writes 0x11AA3344 to word 4. A signed byte load from 0x12 returns 0xFFFFFFAA; an unsigned one returns 0x000000AA.
- Half store 0x8001 to 0x16 over word 0x0, then a signed half load from 0x16 → word 5 = 0x80010000 and the load returns 0xFFFF8001.
- Half load from 0x13, word store to 0x102, size=11 request, and word load from 400 (ENTRIES=100) → each gives resp_valid with resp_err=1 one cycle after acceptance, ram_WE stays 0, and resp_rdata=0.
- Rst asserted during ST_WR of a store to 0x20 → no write to word 8 (it reads back its prior value), req_ready=1 after reset, and no resp_valid.
- With RAM2_LSU_PERF_EN, run 3 loads, 2 stores and 1 error → load_cnt=3, store_cnt=2, err_cnt=1. All three read 0 after Rst.
